// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing one unified memory between fetch and data requesters.
// Define MEM_ARB_FETCH_BUF_EN to add a one-entry fetch buffer that short-circuits repeated fetches.
module mem_arbiter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  typedef enum logic {OWN_IF, OWN_DM} own_t;

  localparam logic [3:0] LAT_CNT = 4'(MEM_LATENCY);

  state_t      state_q;
  own_t        own_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic        mem_en_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;
  logic        if_ready_q;
  logic        dm_ready_q;

  logic        done_now;
  logic        fb_hit;
  logic [31:0] fb_data;

  assign done_now = (state_q == S_WAIT) && (cnt_q == LAT_CNT);

`ifdef MEM_ARB_FETCH_BUF_EN
  logic        fb_valid_q;
  logic [31:0] fb_addr_q;
  logic [31:0] fb_data_q;

  assign fb_hit  = fb_valid_q && (if_addr == fb_addr_q);
  assign fb_data = fb_data_q;

  // Filled by every completed fetch; a granted data write to the same word drops it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fb_valid_q <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
    end else if (done_now && own_q == OWN_IF) begin
      fb_valid_q <= 1'b1;
      fb_addr_q  <= mem_addr_q;
      fb_data_q  <= mem_rdata;
    end else if (state_q == S_IDLE && dm_req && dm_we && dm_addr == fb_addr_q) begin
      fb_valid_q <= 1'b0;
    end
  end
`else
  assign fb_hit  = 1'b0;
  assign fb_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      own_q       <= OWN_IF;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (dm_req) begin
            own_q       <= OWN_DM;
            we_q        <= dm_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= dm_we;
            mem_addr_q  <= dm_addr;
            mem_wdata_q <= dm_wdata;
            cnt_q       <= '0;
            state_q     <= S_WAIT;
          end else if (if_req && fb_hit) begin
            own_q      <= OWN_IF;
            if_rdata_q <= fb_data;
            if_ready_q <= 1'b1;
            state_q    <= S_DONE;
          end else if (if_req) begin
            own_q       <= OWN_IF;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b1;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 4'd1;
          if (done_now) begin
            if (own_q == OWN_DM) begin
              dm_rdata_q <= we_q ? 32'd0 : mem_rdata;
              dm_ready_q <= 1'b1;
            end else begin
              if_rdata_q <= mem_rdata;
              if_ready_q <= 1'b1;
            end
            state_q <= S_DONE;
          end
        end
        // Ready pulse cycle: no arbitration, so a still-held request is not re-issued here.
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ready  = dm_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected responses, a monitor checks data and timing.
// The fetch-buffer model follows MEM_ARB_FETCH_BUF_EN like the design.
module tb_mem_arbiter;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  mem_arbiter #(.MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int issue; logic [31:0] addr; logic we; logic [31:0] data; } txn_t;
  typedef struct { int c; logic [31:0] addr; logic we; } memop_t;
  typedef struct { int due; logic [31:0] data; } rd_t;

  txn_t   if_q[$];
  txn_t   dm_q[$];
  memop_t memq[$];
  rd_t    rdq[$];
  logic [31:0] shadow [logic [31:0]];
  logic [31:0] memarr [logic [31:0]];

  int tests = 0;
  int fails = 0;
`ifdef MEM_ARB_FETCH_BUF_EN
  bit fb_en = 1'b1;
`else
  bit fb_en = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return (a * 32'h0100_0193) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  // Memory device: writes take effect on the strobe, read data appears exactly L cycles later.
  initial begin : memory_model
    rd_t r;
    forever begin
      @(negedge clk);
      while (rdq.size() > 0 && rdq[0].due < cyc) void'(rdq.pop_front());
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        r = rdq.pop_front();
        mem_rdata = r.data;
      end else begin
        mem_rdata = $urandom;
      end
      if (mem_en) begin
        if (mem_we) memarr[mem_addr] = mem_wdata;
        else rdq.push_back('{cyc + L, memarr.exists(mem_addr) ? memarr[mem_addr] : init_word(mem_addr)});
      end
    end
  end

  // Reference: every access is granted at max(issue, first idle cycle); fetch hits take 1 cycle, others L+2.
  int          free_cyc = 0;
  bit          fb_valid = 1'b0;
  logic [31:0] fb_addr = '0;
  logic [31:0] last_if = '0;
  logic [31:0] last_dm = '0;

  task automatic serve(input bit is_if);
    txn_t   t;
    memop_t m;
    bit     hit;
    int     g;
    if (is_if ? (if_q.size() == 0) : (dm_q.size() == 0)) begin
      check(is_if ? "if_unexpected_ready" : "dm_unexpected_ready", 32'd1, 32'd0);
      return;
    end
    t   = is_if ? if_q.pop_front() : dm_q.pop_front();
    hit = fb_en && is_if && fb_valid && (t.addr == fb_addr);
    g   = (t.issue > free_cyc) ? t.issue : free_cyc;
    check(is_if ? "if_ready_cycle" : "dm_ready_cycle", cyc, g + (hit ? 1 : L + 2));
    check(is_if ? "if_rdata" : "dm_rdata", is_if ? if_rdata : dm_rdata, t.data);
    if (!hit) begin
      if (memq.size() == 0) begin
        check("mem_en_missing", 32'd0, 32'd1);
      end else begin
        m = memq.pop_front();
        check("mem_en_cycle", m.c, g + 1);
        check("mem_addr", m.addr, t.addr);
        check("mem_we", {31'd0, m.we}, {31'd0, t.we});
      end
    end
    $display("[TB] %s %s addr=%h data=%h issue=%0d ready=%0d%s", is_if ? "IF" : "DM",
             t.we ? "WR" : "RD", t.addr, is_if ? if_rdata : dm_rdata, t.issue, cyc, hit ? " (buffered)" : "");
    free_cyc = cyc + 1;
    if (is_if) begin
      fb_valid = 1'b1;
      fb_addr  = t.addr;
      last_if  = if_rdata;
    end else begin
      if (t.we && t.addr == fb_addr) fb_valid = 1'b0;
      last_dm = dm_rdata;
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset) begin
        memq.delete();
        free_cyc = cyc + 1;
        fb_valid = 1'b0;
        last_if  = '0;
        last_dm  = '0;
      end else begin
        if (mem_en) memq.push_back('{cyc, mem_addr, mem_we});
        if (if_ready || dm_ready) check("ready_overlap", {31'd0, if_ready & dm_ready}, 32'd0);
        if (if_ready) serve(1'b1);
        else check("if_rdata_hold", if_rdata, last_if);
        if (dm_ready) serve(1'b0);
        else check("dm_rdata_hold", dm_rdata, last_dm);
      end
    end
  end

  task automatic if_access(input logic [31:0] a, input int gap);
    txn_t t;
    bit   got = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    t = '{cyc, a, 1'b0, shadow_rd(a)};
    if_q.push_back(t);
    if_req  = 1'b1;
    if_addr = a;
    for (int k = 0; k < 100 && !got; k++) begin @(negedge clk); got = if_ready; end
    if (!got) check("if_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic dm_access(input logic we, input logic [31:0] a, input logic [31:0] wd, input int gap);
    txn_t t;
    bit   got = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    t = '{cyc, a, we, we ? 32'd0 : shadow_rd(a)};
    if (we) shadow[a] = wd;
    dm_q.push_back(t);
    dm_req   = 1'b1;
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = wd;
    for (int k = 0; k < 100 && !got; k++) begin @(negedge clk); got = dm_ready; end
    if (!got) check("dm_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    dm_req = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_readies", {30'd0, if_ready, dm_ready}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed: lone fetch, simultaneous requests, write-then-read, fetch buffer sequence.
    if_access(32'h0, 0);
    fork
      if_access(32'h4, 0);
      dm_access(1'b0, 32'h54, 32'h0, 0);
    join
    dm_access(1'b1, 32'h54, 32'h7, 0);
    dm_access(1'b0, 32'h54, 32'h0, 0);
    if_access(32'h8, 1);
    if_access(32'h8, 0);
    dm_access(1'b1, 32'h8, 32'hCAFE_0008, 0);
    if_access(32'h8, 0);

    // Random: fetches from a small code region, data traffic to a separate region.
    fork
      repeat (60) if_access({27'd0, 3'($urandom_range(0, 7)), 2'b00}, $urandom_range(0, 3));
      repeat (60) dm_access(1'($urandom), 32'h100 | {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                            $urandom, $urandom_range(0, 4));
    join

    // Reset during WAIT with cnt==1 abandons the access.
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
    @(posedge clk); #1;
    check("abort_mem_en_issued", {31'd0, mem_en}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0; dm_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("abort_mem_en", {31'd0, mem_en}, 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    for (int k = 0; k < L + 4; k++) begin
      check("abort_no_ready", {30'd0, if_ready, dm_ready}, 32'd0);
      @(posedge clk); #1;
    end
    if_access(32'h10, 0);
    repeat (3) @(posedge clk);
    #1;

    check("if_queue_empty", if_q.size(), 32'd0);
    check("dm_queue_empty", dm_q.size(), 32'd0);
    check("extra_mem_en", memq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
